// File: rtl/demorgan_pkg.sv
// Shared definitions for the De Morgan sweep checker.
//   MODE_*  : encodings of the 2-bit mode input (2'b11 behaves as MODE_LAW1)
//   state_t : sweep controller states
package demorgan_pkg;

  localparam logic [1:0] MODE_LAW1  = 2'b00;
  localparam logic [1:0] MODE_LAW2  = 2'b01;
  localparam logic [1:0] MODE_FAULT = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/demorgan_sweep_checker_eval.sv
// Combinational evaluator for both sides of the selected De Morgan law.
// Ports:
//   i_vec  [N-1:0] : input vector under test
//   i_mode [1:0]   : selected law (latched copy from the controller)
//   o_lhs          : left-hand side of the law
//   o_rhs          : right-hand side of the law
module demorgan_eval
  import demorgan_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0] i_vec,
  input  logic [1:0]   i_mode,
  output logic         o_lhs,
  output logic         o_rhs
);

  always_comb begin
    // First law is the default so the unused encoding 2'b11 falls back to it.
    o_lhs = ~(&i_vec);
    o_rhs = |(~i_vec);
    case (i_mode)
      MODE_LAW2: begin
        o_lhs = ~(|i_vec);
        o_rhs = &(~i_vec);
      end
      MODE_FAULT: begin
        // Second law with the right side deliberately flipped only at all-ones.
        o_lhs = ~(|i_vec);
        o_rhs = (&(~i_vec)) ^ (&i_vec);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/demorgan_sweep_checker.sv
// Exhaustive on-board sweeper for De Morgan identities over N inputs.
// Steps vec through 0..2^N-1, holding each value HOLD cycles, compares both
// sides of the selected law on the last hold cycle and records failures.
// Ports:
//   clk, rst_n          : clock (rising edge), synchronous active-low reset
//   start               : begins a sweep from IDLE or DONE; ignored while sweeping
//   mode [1:0]          : law select, latched at start
//   vec [N-1:0]         : vector currently applied
//   lhs, rhs            : both sides of the law for vec
//   busy, done          : sweeping / sweep finished (level)
//   mismatch            : one-cycle pulse after a failing compare
//   err_count [N:0]     : failing vectors in current/last sweep
//   first_err_vec [N-1:0]: first failing vector, 0 if none
//   pass                : done with no failures
module demorgan_sweep_checker
  import demorgan_pkg::*;
#(
  parameter int N    = 2,
  parameter int HOLD = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   mode,
  output logic [N-1:0] vec,
  output logic         lhs,
  output logic         rhs,
  output logic         busy,
  output logic         done,
  output logic         mismatch,
  output logic [N:0]   err_count,
  output logic [N-1:0] first_err_vec,
  output logic         pass
);

  localparam int            HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

  state_t        r_state;
  state_t        w_next_state;
  logic [N-1:0]  r_vec;
  logic [HW-1:0] r_hold;
  logic [1:0]    r_mode;
  logic [N:0]    r_err;
  logic [N-1:0]  r_first;
  logic          r_mismatch;

  logic          w_lhs;
  logic          w_rhs;
  logic          w_compare;
  logic          w_last;

  demorgan_eval #(.N(N)) u_eval (
    .i_vec  (r_vec),
    .i_mode (r_mode),
    .o_lhs  (w_lhs),
    .o_rhs  (w_rhs)
  );

  assign w_last = (r_vec == {N{1'b1}});

  always_comb begin
    w_next_state = r_state;
    w_compare    = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start) w_next_state = RUN;
      end
      RUN: begin
        w_compare = (r_hold == HOLD_LAST);
        if (w_compare && w_last) w_next_state = DONE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_vec      <= '0;
      r_hold     <= '0;
      r_mode     <= MODE_LAW1;
      r_err      <= '0;
      r_first    <= '0;
      r_mismatch <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_mismatch <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_mode  <= mode;
            r_err   <= '0;
            r_first <= '0;
            r_hold  <= '0;
            r_vec   <= '0;
          end
        end
        RUN: begin
          if (w_compare) begin
            r_mismatch <= (w_lhs != w_rhs);
            if (w_lhs != w_rhs) begin
              r_err <= r_err + (N+1)'(1);
              if (r_err == '0) r_first <= r_vec;
            end
            // vec stays at all-ones once the sweep ends
            if (!w_last) begin
              r_vec  <= r_vec + N'(1);
              r_hold <= '0;
            end
          end else begin
            r_hold <= r_hold + HW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign vec           = r_vec;
  assign lhs           = w_lhs;
  assign rhs           = w_rhs;
  assign busy          = (r_state == RUN);
  assign done          = (r_state == DONE);
  assign mismatch      = r_mismatch;
  assign err_count     = r_err;
  assign first_err_vec = r_first;
  assign pass          = (r_state == DONE) && (r_err == '0);

endmodule

// File: tb/tb_demorgan_sweep_checker.sv
module tb_demorgan_sweep_checker;

  typedef struct {
    logic [7:0] vec;
    logic       busy;
    logic       done;
    logic       mm;
    logic [8:0] err;
    logic [7:0] first;
    logic       lhs;
    logic       rhs;
    logic       pass;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_s   [3];
  logic       start_s [3];
  logic [1:0] mode_s  [3];

  int n_cmp  = 0;
  int n_fail = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  // Instance 0: N=2 HOLD=1
  logic [1:0] a_vec, a_first;
  logic [2:0] a_err;
  logic a_lhs, a_rhs, a_busy, a_done, a_mm, a_pass;
  // Instance 1: N=3 HOLD=4
  logic [2:0] b_vec, b_first;
  logic [3:0] b_err;
  logic b_lhs, b_rhs, b_busy, b_done, b_mm, b_pass;
  // Instance 2: N=2 HOLD=2
  logic [1:0] c_vec, c_first;
  logic [2:0] c_err;
  logic c_lhs, c_rhs, c_busy, c_done, c_mm, c_pass;

  demorgan_sweep_checker #(.N(2), .HOLD(1)) u_a (
    .clk(clk), .rst_n(rst_s[0]), .start(start_s[0]), .mode(mode_s[0]),
    .vec(a_vec), .lhs(a_lhs), .rhs(a_rhs), .busy(a_busy), .done(a_done),
    .mismatch(a_mm), .err_count(a_err), .first_err_vec(a_first), .pass(a_pass));

  demorgan_sweep_checker #(.N(3), .HOLD(4)) u_b (
    .clk(clk), .rst_n(rst_s[1]), .start(start_s[1]), .mode(mode_s[1]),
    .vec(b_vec), .lhs(b_lhs), .rhs(b_rhs), .busy(b_busy), .done(b_done),
    .mismatch(b_mm), .err_count(b_err), .first_err_vec(b_first), .pass(b_pass));

  demorgan_sweep_checker #(.N(2), .HOLD(2)) u_c (
    .clk(clk), .rst_n(rst_s[2]), .start(start_s[2]), .mode(mode_s[2]),
    .vec(c_vec), .lhs(c_lhs), .rhs(c_rhs), .busy(c_busy), .done(c_done),
    .mismatch(c_mm), .err_count(c_err), .first_err_vec(c_first), .pass(c_pass));

  task automatic observe(input int inst, output exp_t o);
    case (inst)
      0: begin
        o.vec = 8'(a_vec); o.busy = a_busy; o.done = a_done; o.mm = a_mm;
        o.err = 9'(a_err); o.first = 8'(a_first); o.lhs = a_lhs; o.rhs = a_rhs; o.pass = a_pass;
      end
      1: begin
        o.vec = 8'(b_vec); o.busy = b_busy; o.done = b_done; o.mm = b_mm;
        o.err = 9'(b_err); o.first = 8'(b_first); o.lhs = b_lhs; o.rhs = b_rhs; o.pass = b_pass;
      end
      default: begin
        o.vec = 8'(c_vec); o.busy = c_busy; o.done = c_done; o.mm = c_mm;
        o.err = 9'(c_err); o.first = 8'(c_first); o.lhs = c_lhs; o.rhs = c_rhs; o.pass = c_pass;
      end
    endcase
  endtask

  // Reference for both sides of a law, built from bit counts.
  function automatic logic [1:0] model_lr(input int v, input int n, input logic [1:0] md);
    int  ones = 0;
    logic l, r;
    for (int b = 0; b < n; b++) if (((v >> b) & 1) == 1) ones++;
    if (md == 2'b01 || md == 2'b10) begin
      l = (ones == 0);
      r = (ones == 0);
      if (md == 2'b10 && ones == n) r = ~r;
    end else begin
      l = (ones != n);
      r = (ones < n);
    end
    return {l, r};
  endfunction

  // Runs one full sweep: start is driven at the current negedge; every cycle
  // from the first busy cycle to one cycle past the first done cycle is
  // checked against the scoreboard. Mode is flipped during the sweep, and
  // start is re-asserted for one cycle at glitch_j (negative = never).
  task automatic run_sweep(input int inst, input int n, input int hold,
                           input logic [1:0] md, input int glitch_j);
    int total = (1 << n) * hold;
    int errs = 0;
    logic [7:0] first = 8'd0;
    exp_t e, o;
    logic [1:0] lr;
    int j;
    for (int k = 0; k <= total; k++) begin
      e.vec  = (k < total) ? 8'(k / hold) : 8'((1 << n) - 1);
      e.busy = (k < total);
      e.done = (k == total);
      e.mm   = 1'b0;
      if (k >= hold && (k % hold) == 0) begin
        lr = model_lr(k / hold - 1, n, md);
        if (lr[1] != lr[0]) begin
          e.mm = 1'b1;
          if (errs == 0) first = 8'(k / hold - 1);
          errs++;
        end
      end
      e.err   = 9'(errs);
      e.first = first;
      lr      = model_lr(int'(e.vec), n, md);
      e.lhs   = lr[1];
      e.rhs   = lr[0];
      e.pass  = e.done && (errs == 0);
      sbq.push_back(e);
    end
    start_s[inst] = 1'b1;
    mode_s[inst]  = md;
    @(negedge clk);
    start_s[inst] = 1'b0;
    mode_s[inst]  = ~md;
    j = 0;
    while (sbq.size() > 0) begin
      observe(inst, o);
      e = sbq.pop_front();
      n_cmp++; if (o.vec !== e.vec) begin n_fail++; $display("FAIL vec inst%0d j=%0d got %0d want %0d", inst, j, o.vec, e.vec); end
      n_cmp++; if (o.busy !== e.busy) begin n_fail++; $display("FAIL busy inst%0d j=%0d got %b want %b", inst, j, o.busy, e.busy); end
      n_cmp++; if (o.done !== e.done) begin n_fail++; $display("FAIL done inst%0d j=%0d got %b want %b", inst, j, o.done, e.done); end
      n_cmp++; if (o.mm !== e.mm) begin n_fail++; $display("FAIL mismatch inst%0d j=%0d got %b want %b", inst, j, o.mm, e.mm); end
      n_cmp++; if (o.err !== e.err) begin n_fail++; $display("FAIL err_count inst%0d j=%0d got %0d want %0d", inst, j, o.err, e.err); end
      n_cmp++; if (o.first !== e.first) begin n_fail++; $display("FAIL first_err_vec inst%0d j=%0d got %0d want %0d", inst, j, o.first, e.first); end
      n_cmp++; if (o.lhs !== e.lhs || o.rhs !== e.rhs) begin n_fail++; $display("FAIL lhs_rhs inst%0d j=%0d got %b%b want %b%b", inst, j, o.lhs, o.rhs, e.lhs, e.rhs); end
      n_cmp++; if (o.pass !== e.pass) begin n_fail++; $display("FAIL pass inst%0d j=%0d got %b want %b", inst, j, o.pass, e.pass); end
      start_s[inst] = (j == glitch_j);
      j++;
      @(negedge clk);
    end
    observe(inst, o);
    n_cmp++; if (o.done !== 1'b1 || o.busy !== 1'b0 || o.mm !== 1'b0) begin
      n_fail++; $display("FAIL hold_done inst%0d got done=%b busy=%b mm=%b want 1 0 0", inst, o.done, o.busy, o.mm);
    end
    n_cmp++; if (o.err !== 9'(errs)) begin n_fail++; $display("FAIL final_err inst%0d got %0d want %0d", inst, o.err, errs); end
  endtask

  task automatic test_reset();
    exp_t o;
    for (int i = 0; i < 3; i++) begin rst_s[i] = 1'b0; start_s[i] = 1'b0; mode_s[i] = 2'b00; end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      observe(i, o);
      n_cmp++;
      if (o.vec !== 8'd0 || o.busy !== 1'b0 || o.done !== 1'b0 || o.mm !== 1'b0 ||
          o.err !== 9'd0 || o.first !== 8'd0 || o.pass !== 1'b0) begin
        n_fail++;
        $display("FAIL reset inst%0d got vec=%0d busy=%b done=%b mm=%b err=%0d first=%0d pass=%b want all 0",
                 i, o.vec, o.busy, o.done, o.mm, o.err, o.first, o.pass);
      end
      rst_s[i] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic test_law1();      run_sweep(0, 2, 1, 2'b00, -1); endtask
  task automatic test_law2();      run_sweep(0, 2, 1, 2'b01, -1); endtask
  task automatic test_fault();     run_sweep(0, 2, 1, 2'b10, -1); endtask
  task automatic test_back_to_back(); run_sweep(0, 2, 1, 2'b00, -1); endtask
  task automatic test_hold_glitch(); run_sweep(1, 3, 4, 2'b00, 10); endtask

  task automatic test_mid_reset();
    exp_t o;
    start_s[2] = 1'b1;
    mode_s[2]  = 2'b10;
    @(negedge clk);
    start_s[2] = 1'b0;
    repeat (4) @(negedge clk);
    observe(2, o);
    n_cmp++; if (o.vec !== 8'd2 || o.busy !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_vec got vec=%0d busy=%b want 2 1", o.vec, o.busy);
    end
    rst_s[2] = 1'b0;
    @(negedge clk);
    observe(2, o);
    n_cmp++;
    if (o.vec !== 8'd0 || o.busy !== 1'b0 || o.done !== 1'b0 || o.mm !== 1'b0 ||
        o.err !== 9'd0 || o.first !== 8'd0 || o.pass !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset got vec=%0d busy=%b done=%b mm=%b err=%0d first=%0d pass=%b want all 0",
               o.vec, o.busy, o.done, o.mm, o.err, o.first, o.pass);
    end
    rst_s[2] = 1'b1;
    @(negedge clk);
    run_sweep(2, 2, 2, 2'b10, -1);
  endtask

  initial begin
    test_reset();
    test_law1();
    test_law2();
    test_fault();
    test_back_to_back();
    test_hold_glitch();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
